// File: rtl/updown_step_ctrl_if.sv
// Command/status bundle between the up/down step sequencer and its datapath/buttons.
interface updown_step_ctrl_if;
  logic       U;
  logic       D;
  logic       CM;
  logic       Cm;
  logic       ld;
  logic       clr;
  logic       s;
  logic       blocked;
  logic       busy;
  logic [2:0] state;

  // Sequencer side: consumes buttons and datapath status, issues commands.
  modport master (
    input  U, D, CM, Cm,
    output ld, clr, s, blocked, busy, state
  );

  // Datapath/stimulus side.
  modport slave (
    output U, D, CM, Cm,
    input  ld, clr, s, blocked, busy, state
  );
endinterface

// File: rtl/updown_step_ctrl.sv
// Up/down counter sequencer: synchronises and debounces U/D, arbitrates them,
// issues one-cycle ld/clr commands with auto-repeat and refuses steps at the limits.
module updown_step_ctrl #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned CLR_ON_BOTH   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_step_ctrl_if.master   bus
);

  localparam int unsigned CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TMR_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W  = (TMR_MX > 2) ? $clog2(TMR_MX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_WAIT    = 3'd2,
    S_BOTH    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         w_raw;
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_filt;
  logic [CNT_W-1:0]   r_deb_cnt [2];
  logic               r_dir;
  logic               r_first;
  logic [TMR_W-1:0]   r_timer;
  logic               r_ld;
  logic               r_clr;
  logic               r_s;
  logic               r_blocked;
  logic               r_busy;
  logic               w_uf;
  logic               w_df;
  logic               w_dir_btn;
  logic               w_opp_btn;
  logic               w_limit;

  assign w_raw     = {bus.D, bus.U};
  assign w_uf      = r_filt[0];
  assign w_df      = r_filt[1];
  assign w_dir_btn = r_dir ? w_uf : w_df;
  assign w_opp_btn = r_dir ? w_df : w_uf;
  assign w_limit   = (r_dir & bus.CM) | (~r_dir & bus.Cm);

  // Two-flop synchronisers for the raw buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: filtered level flips after DEB_CYCLES consecutive disagreeing synced cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          r_filt[i]    <= ~r_filt[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_uf & w_df)      w_next = S_BOTH;
        else if (w_uf ^ w_df) w_next = S_STEP;
      end
      S_STEP:    w_next = S_WAIT;
      S_WAIT: begin
        if (w_opp_btn)           w_next = S_BOTH;
        else if (!w_dir_btn)     w_next = S_IDLE;
        else if (r_timer == '0)  w_next = S_STEP;
      end
      S_BOTH:    w_next = S_RELEASE;
      S_RELEASE: if (!w_uf && !w_df) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Direction latch, first-step flag and repeat timer.
  // The timer is loaded with target-2 so the next STEP lands exactly target cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir   <= 1'b0;
      r_first <= 1'b0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_uf ^ w_df) begin
            r_dir   <= w_uf;
            r_first <= 1'b1;
          end
        end
        S_STEP: begin
          r_first <= 1'b0;
          r_timer <= r_first ? TMR_W'(REPEAT_DELAY - 2) : TMR_W'(REPEAT_PERIOD - 2);
        end
        S_WAIT: begin
          if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered command/status outputs decoded from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld      <= 1'b0;
      r_clr     <= 1'b0;
      r_s       <= 1'b0;
      r_blocked <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ld      <= (r_state == S_STEP) & ~w_limit;
      r_s       <= (r_state == S_STEP) & ~w_limit & r_dir;
      r_blocked <= (r_state == S_STEP) & w_limit;
      r_clr     <= (r_state == S_BOTH) & (CLR_ON_BOTH != 0);
      r_busy    <= (w_next != S_IDLE);
    end
  end

  assign bus.ld      = r_ld;
  assign bus.clr     = r_clr;
  assign bus.s       = r_s;
  assign bus.blocked = r_blocked;
  assign bus.busy    = r_busy;
  assign bus.state   = r_state;

endmodule
